// File: rtl/frac_div_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frac_div_sched_if : config handshake and divider outputs bundle      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface frac_div_sched_if #(
  parameter int CW = 8,
  parameter int PW = 5
);
  logic          cfg_valid;
  logic [CW-1:0] cfg_m;
  logic [PW-1:0] cfg_n;
  logic          cfg_ready;
  logic          cfg_err;
  logic          busy;
  logic          frame_start;
  logic          per_start;
  logic [PW-1:0] per_len;
  logic          clk_out;

  modport master (
    output cfg_valid, cfg_m, cfg_n,
    input  cfg_ready, cfg_err, busy, frame_start, per_start, per_len, clk_out
  );

  modport slave (
    input  cfg_valid, cfg_m, cfg_n,
    output cfg_ready, cfg_err, busy, frame_start, per_start, per_len, clk_out
  );
endinterface
`default_nettype wire

// File: rtl/frac_div_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frac_div_sched : M/N fractional clock divider with on-chip schedule  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module frac_div_sched #(
  parameter int CW = 8,
  parameter int PW = 5
) (
  input  logic              clk_in,
  input  logic              rst,
  frac_div_sched_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam int         KW     = (CW > 1) ? $clog2(CW) : 1;
  localparam int         LW     = CW + 2 * PW;
  localparam logic [KW-1:0] c_k_last = KW'(CW - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] quo_q, quo_d;
  logic [PW-1:0] rem_q, rem_d;
  logic [PW-1:0] n_q, n_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] cc_q, cc_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] pm_q, pm_d;
  logic [PW-1:0] pn_q, pn_d;
  logic          err_q, err_d;

  logic          w_ready, w_acc, w_ok, w_take;
  logic          w_lt2n, w_ovf;
  logic [LW-1:0] w_lim;
  logic [PW-1:0] w_d, w_a, w_len;
  logic          w_run, w_per_end, w_frame_end;
  logic [PW:0]   w_trial, w_sub;
  logic          w_ge;

  assign w_ready = (state_q == S_IDLE) || ((state_q == S_RUN) && !pend_q);
  assign w_acc   = bus.cfg_valid && w_ready;

  // D >= 2^PW-1 is detected as M >= N*(2^PW-1), avoiding a divider here.
  assign w_lt2n  = {1'b0, bus.cfg_m} < ((CW+1)'(bus.cfg_n) << 1);
  assign w_lim   = (LW'(bus.cfg_n) << PW) - LW'(bus.cfg_n);
  assign w_ovf   = LW'(bus.cfg_m) >= w_lim;
  assign w_ok    = (bus.cfg_n != '0) && !w_lt2n && !w_ovf;
  assign w_take  = w_acc && w_ok;

  // Short periods (length D) first, then R long periods (length D+1).
  assign w_d         = PW'(quo_q);
  assign w_a         = n_q - rem_q;
  assign w_len       = (pc_q < w_a) ? w_d : (w_d + 1'b1);
  assign w_run       = (state_q == S_RUN);
  assign w_per_end   = (cc_q == (w_len - 1'b1));
  assign w_frame_end = w_per_end && (pc_q == (n_q - 1'b1));

  // One restoring-division step: quotient bits shift in where dividend bits leave.
  assign w_trial = {rem_q, quo_q[CW-1]};
  assign w_ge    = (w_trial >= {1'b0, n_q});
  assign w_sub   = w_trial - {1'b0, n_q};

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    n_d     = n_q;
    k_d     = k_q;
    pc_d    = pc_q;
    cc_d    = cc_q;
    pend_d  = pend_q;
    pm_d    = pm_q;
    pn_d    = pn_q;
    err_d   = w_acc && !w_ok;

    case (state_q)
      S_IDLE: begin
        if (w_take) begin
          state_d = S_CALC;
          quo_d   = bus.cfg_m;
          n_d     = bus.cfg_n;
          rem_d   = '0;
          k_d     = '0;
        end
      end

      S_CALC: begin
        quo_d = {quo_q[CW-2:0], w_ge};
        rem_d = w_ge ? w_sub[PW-1:0] : w_trial[PW-1:0];
        if (k_q == c_k_last) begin
          state_d = S_RUN;
          pc_d    = '0;
          cc_d    = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_RUN: begin
        if (w_take) begin
          pend_d = 1'b1;
          pm_d   = bus.cfg_m;
          pn_d   = bus.cfg_n;
        end
        if (w_frame_end) begin
          pc_d = '0;
          cc_d = '0;
          // A config accepted in the frame's last cycle still catches this boundary.
          if (pend_q || w_take) begin
            state_d = S_CALC;
            k_d     = '0;
            rem_d   = '0;
            pend_d  = 1'b0;
            quo_d   = pend_q ? pm_q : bus.cfg_m;
            n_d     = pend_q ? pn_q : bus.cfg_n;
          end
        end else if (w_per_end) begin
          cc_d = '0;
          pc_d = pc_q + 1'b1;
        end else begin
          cc_d = cc_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      pc_q    <= '0;
      cc_q    <= '0;
      pend_q  <= 1'b0;
      pm_q    <= '0;
      pn_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      n_q     <= n_d;
      k_q     <= k_d;
      pc_q    <= pc_d;
      cc_q    <= cc_d;
      pend_q  <= pend_d;
      pm_q    <= pm_d;
      pn_q    <= pn_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_ready   = w_ready;
  assign bus.cfg_err     = err_q;
  assign bus.busy        = (state_q == S_CALC) || (state_q == S_RUN);
  assign bus.frame_start = w_run && (cc_q == '0) && (pc_q == '0);
  assign bus.per_start   = w_run && (cc_q == '0);
  assign bus.per_len     = w_run ? w_len : '0;
  assign bus.clk_out     = w_run && (cc_q < (w_len >> 1));

endmodule
`default_nettype wire

// File: tb/tb_frac_div_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frac_div_sched : randomized bench with frame-arithmetic model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_frac_div_sched;
  localparam int CW = 8;
  localparam int PW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frac_div_sched_if #(.CW(CW), .PW(PW)) bus ();
  frac_div_sched #(.CW(CW), .PW(PW)) dut (.clk_in(clk), .rst(rst), .bus(bus));

  int nvec  = 0;
  int nfail = 0;

  // Model: 0 idle, 1 calc, 2 run; m_t is the cycle offset inside the frame.
  int m_mode, m_k, m_t, m_M, m_N, m_pend, m_pM, m_pN, m_err;

  function automatic bit cfg_ok(int m, int n);
    return (n != 0) && (m >= 2 * n) && ((m / n) <= (1 << PW) - 2);
  endfunction

  function automatic logic [10:0] model_out();
    logic fs, ps, ck, rdy, bsy;
    int   d, r, a, c, len;
    fs = 0; ps = 0; ck = 0; len = 0;
    rdy = (m_mode == 0) || (m_mode == 2 && m_pend == 0);
    bsy = (m_mode != 0);
    if (m_mode == 2) begin
      d = m_M / m_N; r = m_M % m_N; a = m_N - r;
      if (m_t < a * d) begin c = m_t % d; len = d; end
      else begin c = (m_t - a * d) % (d + 1); len = d + 1; end
      fs = (m_t == 0); ps = (c == 0); ck = (c < len / 2);
    end
    return {rdy, m_err[0], bsy, fs, ps, PW'(len), ck};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {bus.cfg_ready, bus.cfg_err, bus.busy, bus.frame_start,
            bus.per_start, bus.per_len, bus.clk_out};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_t = 0; m_M = 0; m_N = 0;
    m_pend = 0; m_pM = 0; m_pN = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int m, input int n);
    bit rdy, acc, ok;
    rdy = (m_mode == 0) || (m_mode == 2 && m_pend == 0);
    acc = v && rdy;
    ok  = acc && cfg_ok(m, n);
    m_err = (acc && !ok) ? 1 : 0;
    case (m_mode)
      0: if (ok) begin m_mode = 1; m_k = 0; m_M = m; m_N = n; end
      1: if (m_k == CW - 1) begin m_mode = 2; m_t = 0; end else m_k++;
      default: begin
        if (ok) begin m_pend = 1; m_pM = m; m_pN = n; end
        if (m_t == m_M - 1) begin
          if (m_pend != 0) begin
            m_mode = 1; m_k = 0; m_M = m_pM; m_N = m_pN; m_pend = 0;
          end else m_t = 0;
        end else m_t++;
      end
    endcase
  endtask

  task automatic apply(input bit v, input int m, input int n);
    bus.cfg_valid = v;
    bus.cfg_m     = CW'(m);
    bus.cfg_n     = PW'(n);
    model_step(v, m, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] o, e;
    @(negedge clk);
    o = obs_vec(); e = 11'b1_0_0_0_0_00000_0; nvec++;
    if (o !== e) begin nfail++; $display("FAIL reset_values: got %b expected %b", o, e); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL reset_idle cyc %0d: got %b expected %b", i, o, e); end
      apply(0, 0, 0);
    end
  endtask

  task automatic test_basic();
    logic [10:0] o, e;
    for (int i = 0; i < 190; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL basic_87_10 cyc %0d: got %b expected %b", i, o, e); end
      if (i == 0) apply(1, 87, 10); else apply(0, 0, 0);
    end
  endtask

  task automatic test_even();
    logic [10:0] o, e;
    do_reset();
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL even_64_8 cyc %0d: got %b expected %b", i, o, e); end
      if (i == 0) apply(1, 64, 8); else apply(0, 0, 0);
    end
  endtask

  task automatic test_errors();
    logic [10:0] o, e;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL error_cfg cyc %0d: got %b expected %b", i, o, e); end
      case (i)
        5:       apply(1, 50, 0);
        30:      apply(1, 10, 6);
        70:      apply(1, 255, 1);
        100:     apply(1, 7, 4);
        default: apply(0, 0, 0);
      endcase
    end
  endtask

  task automatic test_reconfig_mid();
    logic [10:0] o, e;
    bit sent;
    int hold;
    sent = 0; hold = 0;
    do_reset();
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL reconfig_mid cyc %0d: got %b expected %b", i, o, e); end
      if (i == 0) apply(1, 87, 10);
      else if (!sent && m_mode == 2 && m_t == 40) begin apply(1, 20, 4); sent = 1; hold = 4; end
      else if (hold > 0) begin apply(1, 30, 3); hold--; end
      else apply(0, 0, 0);
    end
  endtask

  task automatic test_last_cycle();
    logic [10:0] o, e;
    bit sent;
    int hold;
    sent = 0; hold = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL last_cycle cyc %0d: got %b expected %b", i, o, e); end
      if (!sent && m_mode == 2 && m_M == 20 && m_t == 19) begin apply(1, 64, 8); sent = 1; hold = 3; end
      else if (hold > 0) begin apply(1, 87, 10); hold--; end
      else apply(0, 0, 0);
    end
  endtask

  task automatic test_random();
    logic [10:0] o, e;
    int m, n, hi;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL random cyc %0d: got %b expected %b", i, o, e); end
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          m = $urandom_range(0, 255); n = $urandom_range(0, 31);
        end else begin
          n = $urandom_range(1, 10);
          hi = (30 * n > 255) ? 255 : 30 * n;
          m = $urandom_range(2 * n, hi);
        end
        apply(1, m, n);
      end else begin
        apply(0, $urandom_range(0, 255), $urandom_range(0, 31));
      end
    end
  endtask

  task automatic test_midreset();
    logic [10:0] o, e;
    bit hit;
    hit = 0;
    do_reset();
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL midreset_run cyc %0d: got %b expected %b", i, o, e); end
      if (m_mode == 2 && m_t == 50) begin
        hit = 1;
        #2 rst = 1'b0;
        bus.cfg_valid = 1'b0;
        #1 o = obs_vec(); e = 11'b1_0_0_0_0_00000_0; nvec++;
        if (o !== e) begin nfail++; $display("FAIL midreset_async: got %b expected %b", o, e); end
        model_reset();
      end else if (i == 0) apply(1, 87, 10);
      else apply(0, 0, 0);
    end
    nvec++;
    if (!hit) begin nfail++; $display("FAIL midreset_reach: got no RUN offset 50 within 200 cycles, required one"); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      o = obs_vec(); e = model_out(); nvec++;
      if (o !== e) begin nfail++; $display("FAIL midreset_idle cyc %0d: got %b expected %b", i, o, e); end
      apply(0, 0, 0);
    end
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_m     = '0;
    bus.cfg_n     = '0;
    model_reset();
    test_reset();
    test_basic();
    test_even();
    test_errors();
    test_reconfig_mid();
    test_last_cycle();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
